// File: rtl/mul_seq_pkg.sv
// Shared types for the sequential shift-add multiplier.
package mul_seq_pkg;

  // Control FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mul_seq_dp.sv
// Datapath of the sequential multiplier: operand registers, accumulator,
// one shift-add step per clock and the optional sign fix-up on the final load.
// The sign handling is driven by op_signed; the top ties it low when
// MUL_SEQ_SIGNED_EN is not defined, so this unit is always unsigned then.
module mul_seq_dp #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,       // capture operands, clear accumulator
  input  logic                 step,       // one shift-add iteration
  input  logic                 last,       // final iteration: publish product
  input  logic                 op_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [CW-1:0]        cnt,
  output logic [2*WIDTH-1:0]   y
);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] y_q, y_d;
  logic               neg_q, neg_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] partial, sum;

  // Operand capture (magnitudes), accumulate step and final product load.
  // Magnitude of -2^(W-1) is 2^(W-1), which still fits in W unsigned bits.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    y_d      = y_q;
    neg_d    = neg_q;

    a_neg    = op_signed & a[WIDTH-1];
    b_neg    = op_signed & b[WIDTH-1];
    mag_a    = a_neg ? (~a + {{(WIDTH-1){1'b0}}, 1'b1}) : a;
    mag_b    = b_neg ? (~b + {{(WIDTH-1){1'b0}}, 1'b1}) : b;

    partial  = mplier_q[0] ? ({{WIDTH{1'b0}}, mcand_q} << cnt) : '0;
    sum      = acc_q + partial;

    if (load) begin
      mcand_d  = mag_a;
      mplier_d = mag_b;
      acc_d    = '0;
      neg_d    = a_neg ^ b_neg;
    end else if (step) begin
      acc_d    = sum;
      mplier_d = mplier_q >> 1;
      if (last) begin
        y_d = neg_q ? (~sum + {{(2*WIDTH-1){1'b0}}, 1'b1}) : sum;
      end
    end
  end

  // Datapath registers; reset clears the visible product too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      y_q      <= '0;
      neg_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      y_q      <= y_d;
      neg_q    <= neg_d;
    end
  end

  assign y = y_q;

endmodule

// File: rtl/mul_seq_pw.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one multiplier
// bit per clock behind valid/ready handshakes. Holds FSM, iteration counter
// and handshake outputs; arithmetic lives in mul_seq_dp.
// Optional: define MUL_SEQ_SIGNED_EN to add the op_signed port
// (two's-complement operands when op_signed=1).
module mul_seq_pw
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
`ifdef MUL_SEQ_SIGNED_EN
  input  logic                 op_signed,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   y,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           load, step, last;
  logic           sgn;

`ifdef MUL_SEQ_SIGNED_EN
  assign sgn = op_signed;
`else
  assign sgn = 1'b0;
`endif

  // Next-state, counter and handshake outputs. Outputs decode straight
  // from the state register so a reset clears them immediately.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        busy  = 1'b1;
        step  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          last    = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and iteration counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  mul_seq_dp #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_dp (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .step      (step),
    .last      (last),
    .op_signed (sgn),
    .a         (a),
    .b         (b),
    .cnt       (cnt_q),
    .y         (y)
  );

endmodule

// File: tb/tb_mul_seq_pw.sv
// Directed bench for mul_seq_pw: WIDTH=8 instance for the directed cases and
// a WIDTH=16 instance for a random sweep with back-pressure.
module tb_mul_seq_pw;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, out_ready;
  logic [7:0]  a, b;
  logic        in_ready, out_valid, busy;
  logic [15:0] y;
`ifdef MUL_SEQ_SIGNED_EN
  logic        op_signed;
`endif

  logic        v16, r16;
  logic [15:0] a16, b16;
  logic        ir16, ov16, busy16;
  logic [31:0] y16;

  int n_chk  = 0;
  int n_fail = 0;

  mul_seq_pw #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef MUL_SEQ_SIGNED_EN
    .op_signed (op_signed),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .busy      (busy)
  );

  mul_seq_pw #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v16),
    .in_ready  (ir16),
    .a         (a16),
    .b         (b16),
`ifdef MUL_SEQ_SIGNED_EN
    .op_signed (1'b0),
`endif
    .out_valid (ov16),
    .out_ready (r16),
    .y         (y16),
    .busy      (busy16)
  );

  // Drive one operation on the 8-bit instance and report what was observed.
  // lat counts clocks from the accepting edge (inclusive) to out_valid.
  task automatic run_op(input logic [7:0] aa, input logic [7:0] bb, input logic sg,
                        input int hold, input bit keep_valid,
                        output logic [15:0] yy, output int lat, output bit rdy_seen,
                        output bit stable, output bit idle_after);
    @(negedge clk);
    a = aa; b = bb; in_valid = 1'b1; out_ready = 1'b0;
`ifdef MUL_SEQ_SIGNED_EN
    op_signed = sg;
`else
    if (sg) $display("note: signed op requested in unsigned build");
`endif
    rdy_seen = 1'b0;
    stable   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (keep_valid) begin a = ~aa; b = ~bb; end
    else in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    yy = y;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!out_valid || y !== yy) stable = 1'b0;
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    out_ready  = 1'b0;
    idle_after = in_ready && !out_valid && !busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    v16 = 1'b0; r16 = 1'b0; a16 = '0; b16 = '0;
`ifdef MUL_SEQ_SIGNED_EN
    op_signed = 1'b0;
`endif
    #12;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if (y !== 16'h0) begin n_fail++; $display("FAIL reset_y: got %h want 0000", y); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_max();
    logic [15:0] yy; int lat; bit rs, st, ia;
    run_op(8'd255, 8'd255, 1'b0, 0, 1'b0, yy, lat, rs, st, ia);
    n_chk++; if (yy !== 16'hFE01) begin n_fail++; $display("FAIL max_y: got %h want fe01", yy); end
    n_chk++; if (lat !== 9) begin n_fail++; $display("FAIL max_latency: got %0d want 9", lat); end
    n_chk++; if (rs !== 1'b0) begin n_fail++; $display("FAIL max_in_ready_busy: got %b want 0", rs); end
    n_chk++; if (ia !== 1'b1) begin n_fail++; $display("FAIL max_idle_after: got %b want 1", ia); end
  endtask

  task automatic test_no_recapture();
    logic [15:0] yy; int lat; bit rs, st, ia;
    run_op(8'd0, 8'd173, 1'b0, 0, 1'b1, yy, lat, rs, st, ia);
    n_chk++; if (yy !== 16'd0) begin n_fail++; $display("FAIL zero_y: got %0d want 0", yy); end
    n_chk++; if (ia !== 1'b1) begin n_fail++; $display("FAIL zero_idle_after: got %b want 1", ia); end
    run_op(8'd1, 8'd200, 1'b0, 0, 1'b1, yy, lat, rs, st, ia);
    n_chk++; if (yy !== 16'd200) begin n_fail++; $display("FAIL one_y: got %0d want 200", yy); end
    n_chk++; if (lat !== 9) begin n_fail++; $display("FAIL one_latency: got %0d want 9", lat); end
  endtask

  task automatic test_backpressure();
    logic [15:0] yy; int lat; bit rs, st, ia;
    run_op(8'd12, 8'd13, 1'b0, 5, 1'b0, yy, lat, rs, st, ia);
    n_chk++; if (yy !== 16'd156) begin n_fail++; $display("FAIL bp_y: got %0d want 156", yy); end
    n_chk++; if (st !== 1'b1) begin n_fail++; $display("FAIL bp_stable: got %b want 1", st); end
    n_chk++; if (ia !== 1'b1) begin n_fail++; $display("FAIL bp_idle_after: got %b want 1", ia); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] yy; int lat; bit rs, st, ia;
    @(negedge clk);
    a = 8'd100; b = 8'd100; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
    n_chk++; if (y !== 16'h0) begin n_fail++; $display("FAIL rstmid_y: got %h want 0000", y); end
    @(negedge clk); rst_n = 1'b1;
    run_op(8'd3, 8'd7, 1'b0, 0, 1'b0, yy, lat, rs, st, ia);
    n_chk++; if (yy !== 16'd21) begin n_fail++; $display("FAIL rstmid_next_y: got %0d want 21", yy); end
    n_chk++; if (lat !== 9) begin n_fail++; $display("FAIL rstmid_latency: got %0d want 9", lat); end
  endtask

`ifdef MUL_SEQ_SIGNED_EN
  task automatic test_signed();
    logic [15:0] yy; int lat; bit rs, st, ia;
    run_op(8'h80, 8'h80, 1'b1, 0, 1'b0, yy, lat, rs, st, ia);
    n_chk++; if (yy !== 16'h4000) begin n_fail++; $display("FAIL sgn_minmin: got %h want 4000", yy); end
    n_chk++; if (lat !== 9) begin n_fail++; $display("FAIL sgn_latency: got %0d want 9", lat); end
    run_op(8'hFD, 8'd5, 1'b1, 0, 1'b0, yy, lat, rs, st, ia);
    n_chk++; if (yy !== 16'hFFF1) begin n_fail++; $display("FAIL sgn_neg3x5: got %h want fff1", yy); end
    run_op(8'd200, 8'd2, 1'b0, 0, 1'b0, yy, lat, rs, st, ia);
    n_chk++; if (yy !== 16'd400) begin n_fail++; $display("FAIL sgn_off_200x2: got %0d want 400", yy); end
  endtask
`endif

  task automatic test_random8();
    logic [15:0] yy, ex; int lat; bit rs, st, ia;
    logic [7:0] ra, rb;
    for (int k = 0; k < 30; k++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      ex = {8'h0, ra} * {8'h0, rb};
      run_op(ra, rb, 1'b0, int'($urandom_range(0, 3)), 1'b0, yy, lat, rs, st, ia);
      n_chk++; if (yy !== ex || !st) begin n_fail++; $display("FAIL rnd8_y %0d*%0d: got %0d want %0d stable %b", ra, rb, yy, ex, st); end
    end
  endtask

  task automatic test_w16();
    logic [31:0] ex; int lat;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      a16 = 16'($urandom); b16 = 16'($urandom); v16 = 1'b1;
      ex = {16'h0, a16} * {16'h0, b16};
      @(posedge clk);
      @(negedge clk); v16 = 1'b0;
      lat = 1;
      while (!ov16 && lat < 60) begin @(negedge clk); lat++; end
      n_chk++; if (lat !== 17) begin n_fail++; $display("FAIL w16_latency: got %0d want 17", lat); end
      n_chk++; if (y16 !== ex) begin n_fail++; $display("FAIL w16_y %0d*%0d: got %0d want %0d", a16, b16, y16, ex); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      r16 = 1'b1;
      @(negedge clk); r16 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_max();
    test_no_recapture();
    test_backpressure();
    test_reset_mid();
`ifdef MUL_SEQ_SIGNED_EN
    test_signed();
`endif
    test_random8();
    test_w16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
